// File: rtl/acsu_r12k3_if.sv
// Symbol-in / decision-out bundle of the K=3 add-compare-select stage.
// The master side feeds received symbols and observes decisions; the slave
// side is the ACS stage itself.
interface acsu_r12k3_if #(
    parameter int PM_WIDTH = 8
);
    logic                valid_i;
    logic                sop_i;
    logic [1:0]          rx_i;
    logic [1:0]          erase_i;
    logic                valid_o;
    logic [3:0]          dec_bits_o;
    logic [PM_WIDTH-1:0] pm_s0_o;
    logic [PM_WIDTH-1:0] pm_s1_o;
    logic [PM_WIDTH-1:0] pm_s2_o;
    logic [PM_WIDTH-1:0] pm_s3_o;

    modport master (
        output valid_i, sop_i, rx_i, erase_i,
        input  valid_o, dec_bits_o, pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o
    );

    modport slave (
        input  valid_i, sop_i, rx_i, erase_i,
        output valid_o, dec_bits_o, pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o
    );
endinterface

// File: rtl/acsu_r12k3.sv
// Hard-decision branch metric + add-compare-select for the rate-1/2, K=3
// (7,5) Viterbi decoder. Stage 1 registers the four branch metrics, stage 2
// runs ACS with min-normalization and saturating metric storage. The stored
// metrics double as the registered pm outputs, so they only move on a valid
// ACS step and hold otherwise.
module acsu_r12k3 #(
    parameter int PM_WIDTH = 8,
    parameter int INIT_PM  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    acsu_r12k3_if.slave  bus
);

    localparam logic [PM_WIDTH-1:0] INIT_V = PM_WIDTH'(INIT_PM);
    localparam logic [PM_WIDTH:0]   PM_MAX = {1'b0, {PM_WIDTH{1'b1}}};

    // Hamming distance between the received pair and a code pair, with
    // erased bits contributing nothing.
    function automatic logic [1:0] branch_metric(
        input logic [1:0] rx,
        input logic [1:0] er,
        input logic [1:0] code
    );
        logic e1;
        logic e0;
        e1 = (rx[1] ^ code[1]) & ~er[1];
        e0 = (rx[0] ^ code[0]) & ~er[0];
        return {1'b0, e1} + {1'b0, e0};
    endfunction

    // Encoder output pair {c0, c1} for leaving state pred with input u.
    function automatic logic [1:0] code_of(input logic [1:0] pred, input logic u);
        return {u ^ pred[0] ^ pred[1], u ^ pred[1]};
    endfunction

    logic [1:0]          bm_d [4];
    logic [1:0]          bm_q [4];
    logic                v1_q;
    logic                sop1_q;

    logic [PM_WIDTH-1:0] pm_q [4];
    logic [PM_WIDTH-1:0] base [4];
    logic [PM_WIDTH:0]   cand_u [4];
    logic [PM_WIDTH:0]   cand_l [4];
    logic [PM_WIDTH:0]   surv [4];
    logic [PM_WIDTH:0]   surv_min;
    logic [PM_WIDTH-1:0] norm [4];
    logic [3:0]          dec;
    logic [3:0]          dec_q;
    logic                valid_q;

    // Branch metrics for all four code pairs, indexed by {c0, c1}.
    always_comb begin
        bm_d = '{default: '0};
        for (int c = 0; c < 4; c++) begin
            bm_d[c] = branch_metric(bus.rx_i, bus.erase_i, 2'(c));
        end
    end

    // Stage 1: register branch metrics; sop only counts when qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bm_q   <= '{default: '0};
            v1_q   <= 1'b0;
            sop1_q <= 1'b0;
        end else begin
            v1_q   <= bus.valid_i;
            sop1_q <= bus.valid_i & bus.sop_i;
            if (bus.valid_i) begin
                bm_q <= bm_d;
            end
        end
    end

    // Base metrics: a frame start overrides whatever the previous frame left.
    always_comb begin
        base    = '{default: '0};
        base[0] = sop1_q ? '0     : pm_q[0];
        base[1] = sop1_q ? INIT_V : pm_q[1];
        base[2] = sop1_q ? INIT_V : pm_q[2];
        base[3] = sop1_q ? INIT_V : pm_q[3];
    end

    // Add-compare-select: predecessors of s' are {0,s'[1]} (upper) and
    // {1,s'[1]} (lower), both driven by input u = s'[0]. Ties keep upper.
    always_comb begin : acs_comb
        logic [1:0] st;
        logic [1:0] pu;
        logic [1:0] pl;
        st     = '0;
        pu     = '0;
        pl     = '0;
        dec    = '0;
        cand_u = '{default: '0};
        cand_l = '{default: '0};
        surv   = '{default: '0};
        for (int ns = 0; ns < 4; ns++) begin
            st         = 2'(ns);
            pu         = {1'b0, st[1]};
            pl         = {1'b1, st[1]};
            cand_u[ns] = {1'b0, base[pu]}
                       + {{(PM_WIDTH-1){1'b0}}, bm_q[code_of(pu, st[0])]};
            cand_l[ns] = {1'b0, base[pl]}
                       + {{(PM_WIDTH-1){1'b0}}, bm_q[code_of(pl, st[0])]};
            dec[ns]    = cand_l[ns] < cand_u[ns];
            surv[ns]   = dec[ns] ? cand_l[ns] : cand_u[ns];
        end
    end

    // Normalize against the smallest survivor and saturate into PM_WIDTH bits.
    always_comb begin : norm_comb
        logic [PM_WIDTH:0] diff;
        diff     = '0;
        norm     = '{default: '0};
        surv_min = surv[0];
        for (int i = 1; i < 4; i++) begin
            if (surv[i] < surv_min) begin
                surv_min = surv[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            diff    = surv[i] - surv_min;
            norm[i] = (diff > PM_MAX) ? PM_MAX[PM_WIDTH-1:0] : diff[PM_WIDTH-1:0];
        end
    end

    // Stage 2: metric recursion and registered decisions, updated only on a valid step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q[0] <= '0;
            pm_q[1] <= INIT_V;
            pm_q[2] <= INIT_V;
            pm_q[3] <= INIT_V;
            dec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= v1_q;
            if (v1_q) begin
                pm_q  <= norm;
                dec_q <= dec;
            end
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.dec_bits_o = dec_q;
    assign bus.pm_s0_o    = pm_q[0];
    assign bus.pm_s1_o    = pm_q[1];
    assign bus.pm_s2_o    = pm_q[2];
    assign bus.pm_s3_o    = pm_q[3];

endmodule

// File: tb/tb_acsu_r12k3.sv
// Bench for the K=3 ACS stage: hand-derived single-step vectors, a
// trellis-search reference model with a latency-tagged scoreboard, a full
// encode/decode loop with a local traceback, and clamp / async reset checks.
module tb_acsu_r12k3;

    localparam int W     = 8;
    localparam int INIT  = 16;
    localparam int MAXPM = (1 << W) - 1;
    localparam int NBITS = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    acsu_r12k3_if #(.PM_WIDTH(W)) bus  ();
    acsu_r12k3_if #(.PM_WIDTH(W)) bus2 ();

    acsu_r12k3 #(.PM_WIDTH(W), .INIT_PM(INIT))  dut       (.clk(clk), .rst_n(rst_n), .bus(bus));
    acsu_r12k3 #(.PM_WIDTH(W), .INIT_PM(MAXPM)) dut_clamp (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct packed {
        int             due;
        logic [3:0]     dec;
        logic [W-1:0]   p0, p1, p2, p3;
    } obs_t;

    typedef struct packed {
        logic [1:0]     rx;
        logic [1:0]     er;
        logic [3:0]     dec;
        logic [W-1:0]   p0, p1, p2, p3;
    } vec_t;

    vec_t vecs [7];
    obs_t expq [$];
    obs_t capq [$];
    obs_t last;
    int   m_pm [4];
    int   ncyc   = 0;
    int   ncomp  = 0;
    int   nfail  = 0;
    int   vcount = 0;
    bit   mon_en   = 1'b0;
    bit   cap_en   = 1'b0;
    bit   zero_chk = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        ncomp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic model_reset();
        m_pm = '{0, INIT, INIT, INIT};
        expq.delete();
        last.due = 0;
        last.dec = 4'b0;
        last.p0  = W'(0);
        last.p1  = W'(INIT);
        last.p2  = W'(INIT);
        last.p3  = W'(INIT);
    endtask

    // Reference: exhaustive search over every (state, input) transition,
    // keeping the cheapest arrival per next state; upper predecessors are
    // visited first, so a strict '<' leaves ties with them.
    task automatic model_step(input logic sop, input logic [1:0] rx, input logic [1:0] er,
                              output logic [3:0] dec);
        int base [4];
        int best [4];
        int ns, cost, m, d;
        logic [1:0] pb;
        logic u, c0, c1;
        dec  = 4'b0;
        base = sop ? '{0, INIT, INIT, INIT} : m_pm;
        best = '{-1, -1, -1, -1};
        for (int p = 0; p < 4; p++) begin
            for (int ui = 0; ui < 2; ui++) begin
                pb   = 2'(p);
                u    = 1'(ui);
                ns   = ((p & 1) << 1) | ui;
                c0   = u ^ pb[0] ^ pb[1];
                c1   = u ^ pb[1];
                cost = base[p] + ((rx[1] != c0 && !er[1]) ? 1 : 0)
                               + ((rx[0] != c1 && !er[0]) ? 1 : 0);
                if (best[ns] < 0 || cost < best[ns]) begin
                    best[ns] = cost;
                    dec[ns]  = (p >= 2);
                end
            end
        end
        m = best[0];
        for (int i = 1; i < 4; i++) if (best[i] < m) m = best[i];
        for (int i = 0; i < 4; i++) begin
            d       = best[i] - m;
            m_pm[i] = (d > MAXPM) ? MAXPM : d;
        end
    endtask

    task automatic monitor();
        obs_t o, e;
        int mn;
        o.due = ncyc;
        o.dec = bus.dec_bits_o;
        o.p0  = bus.pm_s0_o;
        o.p1  = bus.pm_s1_o;
        o.p2  = bus.pm_s2_o;
        o.p3  = bus.pm_s3_o;
        if (bus.valid_o) begin
            vcount++;
            if (expq.size() == 0) begin
                chk("spurious valid_o", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("latency", o.due, e.due);
                chk("dec_bits", int'(o.dec), int'(e.dec));
                chk("pm_s0", int'(o.p0), int'(e.p0));
                chk("pm_s1", int'(o.p1), int'(e.p1));
                chk("pm_s2", int'(o.p2), int'(e.p2));
                chk("pm_s3", int'(o.p3), int'(e.p3));
            end
            mn = int'(o.p0);
            if (int'(o.p1) < mn) mn = int'(o.p1);
            if (int'(o.p2) < mn) mn = int'(o.p2);
            if (int'(o.p3) < mn) mn = int'(o.p3);
            chk("min pm zero", mn, 0);
            if (zero_chk) begin
                chk("zero run pm_s0", int'(o.p0), 0);
                chk("zero run dec0", int'(o.dec[0]), 0);
            end
            if (cap_en) capq.push_back(o);
            last = o;
        end else begin
            chk("hold dec_bits", int'(o.dec), int'(last.dec));
            chk("hold pm_s0", int'(o.p0), int'(last.p0));
            chk("hold pm_s1", int'(o.p1), int'(last.p1));
            chk("hold pm_s2", int'(o.p2), int'(last.p2));
            chk("hold pm_s3", int'(o.p3), int'(last.p3));
            if (expq.size() > 0 && expq[0].due < ncyc) begin
                chk("missing valid_o", 0, 1);
                void'(expq.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
        if (mon_en) monitor();
    endtask

    task automatic send(input logic v, input logic sop, input logic [1:0] rx, input logic [1:0] er);
        logic [3:0] d;
        obs_t e;
        bus.valid_i = v;
        bus.sop_i   = sop;
        bus.rx_i    = rx;
        bus.erase_i = er;
        if (v) begin
            model_step(sop, rx, er, d);
            e.due = ncyc + 2;
            e.dec = d;
            e.p0  = W'(m_pm[0]);
            e.p1  = W'(m_pm[1]);
            e.p2  = W'(m_pm[2]);
            e.p3  = W'(m_pm[3]);
            expq.push_back(e);
        end
        tick();
    endtask

    initial begin
        obs_t gapless [$];
        logic [1:0] g_rx [6];
        logic [1:0] g_er [6];
        logic [5:0] vpat;
        logic [NBITS-1:0] src;
        logic [NBITS-1:0] dech;
        logic [1:0] enc_st, sym, st;
        logic u;
        int j, k, mn, best;

        bus.valid_i  = 1'b0; bus.sop_i  = 1'b0; bus.rx_i  = 2'b00; bus.erase_i  = 2'b00;
        bus2.valid_i = 1'b0; bus2.sop_i = 1'b0; bus2.rx_i = 2'b00; bus2.erase_i = 2'b00;

        vecs[0] = '{2'b00, 2'b00, 4'b0000, 8'd0, 8'd2, 8'd17, 8'd17};
        vecs[1] = '{2'b11, 2'b00, 4'b0000, 8'd2, 8'd0, 8'd17, 8'd17};
        vecs[2] = '{2'b10, 2'b00, 4'b1000, 8'd0, 8'd0, 8'd15, 8'd15};
        vecs[3] = '{2'b01, 2'b00, 4'b0100, 8'd0, 8'd0, 8'd15, 8'd15};
        vecs[4] = '{2'b11, 2'b11, 4'b0000, 8'd0, 8'd0, 8'd16, 8'd16};
        vecs[5] = '{2'b10, 2'b10, 4'b1000, 8'd0, 8'd1, 8'd16, 8'd16};
        vecs[6] = '{2'b01, 2'b01, 4'b0100, 8'd0, 8'd1, 8'd16, 8'd16};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid_o", int'(bus.valid_o), 0);
        chk("rst dec_bits", int'(bus.dec_bits_o), 0);
        chk("rst pm_s0", int'(bus.pm_s0_o), 0);
        chk("rst pm_s1", int'(bus.pm_s1_o), INIT);
        chk("rst pm_s3", int'(bus.pm_s3_o), INIT);
        chk("rst clamp pm_s2", int'(bus2.pm_s2_o), MAXPM);
        #3 rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        tick();
        tick();

        // Single-symbol frames from hand-derived vectors
        for (int i = 0; i < 7; i++) begin
            send(1'b1, 1'b1, vecs[i].rx, vecs[i].er);
            chk($sformatf("tbl%0d early valid", i), int'(bus.valid_o), 0);
            send(1'b0, 1'b0, 2'b00, 2'b00);
            chk($sformatf("tbl%0d valid_o", i), int'(bus.valid_o), 1);
            chk($sformatf("tbl%0d dec", i), int'(bus.dec_bits_o), int'(vecs[i].dec));
            chk($sformatf("tbl%0d pm0", i), int'(bus.pm_s0_o), int'(vecs[i].p0));
            chk($sformatf("tbl%0d pm1", i), int'(bus.pm_s1_o), int'(vecs[i].p1));
            chk($sformatf("tbl%0d pm2", i), int'(bus.pm_s2_o), int'(vecs[i].p2));
            chk($sformatf("tbl%0d pm3", i), int'(bus.pm_s3_o), int'(vecs[i].p3));
            send(1'b0, 1'b0, 2'b00, 2'b00);
            chk($sformatf("tbl%0d single pulse", i), int'(bus.valid_o), 0);
        end

        // Twenty all-zero symbols after a frame start
        vcount   = 0;
        zero_chk = 1'b1;
        for (int i = 0; i < 20; i++) send(1'b1, (i == 0), 2'b00, 2'b00);
        repeat (4) send(1'b0, 1'b0, 2'b00, 2'b00);
        zero_chk = 1'b0;
        chk("zero run valid count", vcount, 20);

        // Gapless vs gapped delivery of the same frame
        g_rx = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01};
        g_er = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        capq.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 6; i++) send(1'b1, (i == 0), g_rx[i], g_er[i]);
        repeat (3) send(1'b0, 1'b0, 2'b00, 2'b00);
        gapless = capq;
        capq.delete();
        vpat = 6'b101001;
        j = 0;
        k = 0;
        while (j < 6 && k < 24) begin
            if (vpat[k % 6]) begin
                send(1'b1, (j == 0), g_rx[j], g_er[j]);
                j++;
            end else begin
                send(1'b1 & 1'b0, 1'b1, 2'b11, 2'b00);
            end
            k++;
        end
        repeat (3) send(1'b0, 1'b0, 2'b00, 2'b00);
        cap_en = 1'b0;
        chk("gap count", capq.size(), gapless.size());
        if (capq.size() == 6 && gapless.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("gap%0d dec", i), int'(capq[i].dec), int'(gapless[i].dec));
                chk($sformatf("gap%0d pm", i),
                    int'({capq[i].p0, capq[i].p1, capq[i].p2, capq[i].p3}),
                    int'({gapless[i].p0, gapless[i].p1, gapless[i].p2, gapless[i].p3}));
            end
        end

        // Encoded stream with one channel error per ten symbols, decoded by local traceback
        enc_st = 2'b00;
        capq.delete();
        cap_en = 1'b1;
        for (int i = 0; i < NBITS; i++) begin
            u      = 1'($urandom_range(0, 1));
            src[i] = u;
            sym    = {u ^ enc_st[0] ^ enc_st[1], u ^ enc_st[1]};
            enc_st = {enc_st[0], u};
            if (i % 10 == 5) sym[$urandom_range(0, 1)] ^= 1'b1;
            send(1'b1, (i == 0), sym, 2'b00);
        end
        repeat (3) send(1'b0, 1'b0, 2'b00, 2'b00);
        cap_en = 1'b0;
        chk("decode step count", capq.size(), NBITS);
        if (capq.size() == NBITS) begin
            mn   = int'(capq[NBITS-1].p0);
            best = 0;
            if (int'(capq[NBITS-1].p1) < mn) begin mn = int'(capq[NBITS-1].p1); best = 1; end
            if (int'(capq[NBITS-1].p2) < mn) begin mn = int'(capq[NBITS-1].p2); best = 2; end
            if (int'(capq[NBITS-1].p3) < mn) begin mn = int'(capq[NBITS-1].p3); best = 3; end
            st = 2'(best);
            for (int i = NBITS - 1; i >= 0; i--) begin
                dech[i] = st[0];
                st = capq[i].dec[st] ? {1'b1, st[1]} : {1'b0, st[1]};
            end
            for (int i = 0; i < NBITS - 10; i++) begin
                chk($sformatf("decoded bit %0d", i), int'(dech[i]), int'(src[i]));
            end
        end

        // Random symbols, gaps, frame starts and erasures
        for (int i = 0; i < 400; i++) begin
            send(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
        end
        repeat (3) send(1'b0, 1'b0, 2'b00, 2'b00);

        // Saturation with INIT_PM at full scale
        bus2.valid_i = 1'b1; bus2.sop_i = 1'b1; bus2.rx_i = 2'b11; bus2.erase_i = 2'b00;
        tick();
        bus2.valid_i = 1'b0; bus2.sop_i = 1'b0;
        chk("clamp early valid", int'(bus2.valid_o), 0);
        tick();
        chk("clamp valid_o", int'(bus2.valid_o), 1);
        chk("clamp dec", int'(bus2.dec_bits_o), 0);
        chk("clamp pm0", int'(bus2.pm_s0_o), 2);
        chk("clamp pm1", int'(bus2.pm_s1_o), 0);
        chk("clamp pm2", int'(bus2.pm_s2_o), MAXPM);
        chk("clamp pm3", int'(bus2.pm_s3_o), MAXPM);

        // Asynchronous reset with symbols in flight
        for (int i = 0; i < 4; i++) begin
            bus2.valid_i = 1'b1;
            bus2.rx_i    = 2'($urandom_range(0, 3));
            send(1'b1, (i == 0), 2'($urandom_range(0, 3)), 2'b00);
        end
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst valid_o", int'(bus.valid_o), 0);
        chk("async rst dec", int'(bus.dec_bits_o), 0);
        chk("async rst pm0", int'(bus.pm_s0_o), 0);
        chk("async rst pm1", int'(bus.pm_s1_o), INIT);
        chk("async rst pm2", int'(bus.pm_s2_o), INIT);
        chk("async rst pm3", int'(bus.pm_s3_o), INIT);
        chk("async rst clamp valid_o", int'(bus2.valid_o), 0);
        chk("async rst clamp pm0", int'(bus2.pm_s0_o), 0);
        chk("async rst clamp pm1", int'(bus2.pm_s1_o), MAXPM);
        bus.valid_i = 1'b1;
        bus.sop_i   = 1'b1;
        tick();
        tick();
        bus.valid_i  = 1'b0;
        bus.sop_i    = 1'b0;
        bus2.valid_i = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post rst clamp idle", int'(bus2.valid_o), 0);
        end
        send(1'b1, 1'b1, 2'b00, 2'b00);
        chk("post rst early valid", int'(bus.valid_o), 0);
        send(1'b0, 1'b0, 2'b00, 2'b00);
        chk("post rst valid_o", int'(bus.valid_o), 1);
        chk("post rst pm2", int'(bus.pm_s2_o), 17);
        repeat (2) send(1'b0, 1'b0, 2'b00, 2'b00);

        chk("pending expectations", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/acsu_r12k3.md
# acsu_r12k3

Hard-decision branch-metric and add-compare-select stage for the rate-1/2, K=3 (generators 7,5) Viterbi decoder. It consumes received symbol pairs with optional per-bit erasure flags and updates four state path metrics with per-step normalization. Each step it emits the 4-bit survivor decision vector plus the normalized metrics. It sits directly upstream of the traceback unit, and its outputs wire straight to that unit's `valid_i`, `dec_bits_i` and `pm_s*_i`.

## Interface
- `PM_WIDTH`, 8, path-metric width in bits, unsigned.
- `INIT_PM`, 16, start-of-frame metric for states 1–3; state 0 starts at 0. Must be ≤ 2^PM_WIDTH−1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_i` input 1: a symbol is present this cycle.
- `sop_i` input 1: qualified by `valid_i`; this symbol starts a new frame.
- `rx_i` input 2: hard symbol; bit1 = G0 (111) bit, bit0 = G1 (101) bit.
- `erase_i` input 2: per-bit erasure, same bit order; an erased bit contributes 0 to the branch metric.
- `valid_o` output 1: decisions and metrics are valid this cycle.
- `dec_bits_o` output 4: bit k = survivor select for state k; 0 = upper predecessor, 1 = lower predecessor.
- `pm_s0_o`..`pm_s3_o` output PM_WIDTH each: normalized metrics after this step.

## Operation
- **State and trellis convention.**
  - State s = {s[1], s[0]}, with s[0] the most recent input bit.
  - Input u moves s to s' = {s[0], u}.
  - Encoder outputs are c0 = u^s[0]^s[1] and c1 = u^s[1].
- **Predecessors of s'.**
  - Upper predecessor is {0, s'[1]}, selected when dec = 0.
  - Lower predecessor is {1, s'[1]}, selected when dec = 1.
  - Hence state 0 ← {0, 2}, state 1 ← {0, 2}, state 2 ← {1, 3}, state 3 ← {1, 3}, with u = s'[0].
  - This is exactly the traceback unit's path-register topology.
- **Stage 1, registered.**
  - Compute the Hamming branch metric for each of the 4 code pairs: bm(xy) = ((rx_i[1]^x)&~erase_i[1]) + ((rx_i[0]^y)&~erase_i[0]), range 0..2.
  - Register the four bm values together with `valid_i` and `sop_i`.
- **Stage 2, ACS.** Active only when the stage-1 valid is high.
  - Base metrics are {0, INIT_PM, INIT_PM, INIT_PM} if the registered sop is high; otherwise the stored metrics.
  - For each s': cand_u = base[upper] + bm, cand_l = base[lower] + bm, computed at PM_WIDTH+1 bits.
  - dec = (cand_l < cand_u). A tie selects upper (dec = 0).
  - Survivor = the selected candidate.
- **Normalization.**
  - Subtract m = min of the four survivors from each survivor.
  - Clamp each result to 2^PM_WIDTH−1.
  - Store the results as the new metrics, so at least one stored metric is always 0.
- **Outputs.**
  - `dec_bits_o` and `pm_s*_o` are registered, and update only on a valid stage-2 step.
  - When valid is low they hold their last value.
  - `valid_o` is a registered copy of the stage-2 valid.
- No backpressure: the downstream stage accepts every `valid_o` cycle.

## Timing
- Latency: symbol on `valid_i` at cycle t → `valid_o`, `dec_bits_o` and `pm_s*_o` at cycle t+2.
- Throughput: one symbol per cycle; arbitrary `valid_i` gaps are allowed.
- The metric recursion closes within stage 2 in a single cycle; back-to-back symbols must use the metrics from the immediately preceding step.
- Reset values:
  - `valid_o` = 0, `dec_bits_o` = 0.
  - `pm_s0_o` = 0; `pm_s1_o`, `pm_s2_o`, `pm_s3_o` = INIT_PM.
  - All pipeline valids = 0.
- `sop_i` on consecutive valid cycles: each one restarts from the initial metrics.
- `sop_i` without `valid_i` is ignored.
- Reset asserted mid-stream: all in-flight symbols are discarded. The first `valid_o` after release comes 2 cycles after the first accepted `valid_i`.
- Gaps between symbols: stored metrics are untouched and no normalization occurs.

## Test plan
- **Reset then sop, rx = 00, no erase.** Check the cycle when `valid_o` rises 2 cycles later: pm = {0, 2, 17, 17}, `dec_bits_o` = 0000 (states 2 and 3 are ties and pick upper).
- **20 consecutive rx = 00 after sop.** `pm_s0_o` = 0 every step, `valid_o` high for exactly 20 cycles, `dec_bits_o[0]` = 0 throughout.
- **Encode random 200-bit stream, inject 1 bit error per 10 symbols, feed through this block and the traceback unit.** Decoded bits match the source after traceback latency, and min(pm) = 0 at every `valid_o`.
- **sop, rx = 11 with erase = 11.** All bm = 0: pm = {0, 0, INIT_PM, INIT_PM}, dec = 0000.
- **valid_i gaps (1, 0, 0, 1, 0, 1 pattern).** Outputs identical to the gapless sequence apart from timing; outputs hold during gaps.
- **INIT_PM = 2^PM_WIDTH−1, sop, rx = 11.** pm_s2/pm_s3 clamp to 2^PM_WIDTH−1 with no wrap. Then assert reset mid-stream: outputs return to reset values immediately and asynchronously.
